// File: rtl/matrix_scan_bcm.sv
// HUB75-style LED matrix scan controller with binary-coded modulation.
// Shifts one row/plane of pixels column by column, using a load/ready handshake
// with the framebuffer fetch. It then blanks the panel, latches the row and
// starts that plane's display window. The display window overlaps the shifting
// of the next plane.
module matrix_scan_bcm #(
  parameter int COLUMN_WIDTH = 6,
  parameter int ROW_WIDTH    = 4,
  parameter int BPP          = 6,
  parameter int BASE_TIME    = 8,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    pixel_ready,
  output logic [COLUMN_WIDTH-1:0] column_address,
  output logic [ROW_WIDTH-1:0]    row_address,
  output logic [ROW_WIDTH-1:0]    row_address_active,
  output logic [BPP-1:0]          brightness_mask,
  output logic                    pixel_load_start,
  output logic                    clk_pixel,
  output logic                    row_latch,
  output logic                    output_enable,
  output logic                    frame_start
);

  // The longest display window (top plane) must fit in the counter.
  localparam int CNT_W   = $clog2((BASE_TIME << (BPP - 1)) + 1);
  localparam int PLANE_W = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);

  localparam logic [COLUMN_WIDTH-1:0] COL_LAST   = {COLUMN_WIDTH{1'b1}};
  localparam logic [ROW_WIDTH-1:0]    ROW_LAST   = {ROW_WIDTH{1'b1}};
  localparam logic [PLANE_W-1:0]      PLANE_LAST = PLANE_W'(BPP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_DATA,
    S_CLK_HIGH,
    S_CLK_LOW,
    S_WAIT_DISPLAY,
    S_BLANK,
    S_LATCH
  } state_t;

  state_t                  state_q;
  logic [COLUMN_WIDTH-1:0] col_q;
  logic [ROW_WIDTH-1:0]    row_q;
  logic [ROW_WIDTH-1:0]    row_act_q;
  logic [PLANE_W-1:0]      plane_q;
  logic [CNT_W-1:0]        disp_cnt_q;
  logic [BLANK_W-1:0]      blank_cnt_q;
  logic                    load_q;
  logic                    clk_pix_q;
  logic                    latch_q;
  logic                    fstart_q;

  // Scan sequencer: state, addresses, display/blank counters and the
  // single-cycle pulse outputs. The pulses are set on entry to their state.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      row_act_q   <= '0;
      plane_q     <= '0;
      disp_cnt_q  <= '0;
      blank_cnt_q <= '0;
      load_q      <= 1'b0;
      clk_pix_q   <= 1'b0;
      latch_q     <= 1'b0;
      fstart_q    <= 1'b0;
    end else begin
      load_q    <= 1'b0;
      clk_pix_q <= 1'b0;
      latch_q   <= 1'b0;
      fstart_q  <= 1'b0;

      // The display window runs down on its own, whatever the shifter is doing.
      if (disp_cnt_q != '0) begin
        disp_cnt_q <= disp_cnt_q - CNT_W'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_q  <= S_LOAD;
            load_q   <= 1'b1;
            fstart_q <= 1'b1;
          end
        end
        S_LOAD: begin
          state_q <= S_WAIT_DATA;
        end
        S_WAIT_DATA: begin
          if (pixel_ready) begin
            state_q   <= S_CLK_HIGH;
            clk_pix_q <= 1'b1;
          end
        end
        S_CLK_HIGH: begin
          state_q <= S_CLK_LOW;
        end
        S_CLK_LOW: begin
          if (col_q == COL_LAST) begin
            col_q   <= '0;
            state_q <= S_WAIT_DISPLAY;
          end else begin
            col_q   <= col_q + COLUMN_WIDTH'(1);
            state_q <= S_LOAD;
            load_q  <= 1'b1;
          end
        end
        S_WAIT_DISPLAY: begin
          // Never latch into a row that is still being displayed.
          if (disp_cnt_q == '0) begin
            state_q     <= S_BLANK;
            blank_cnt_q <= BLANK_W'(BLANK_CYCLES - 1);
          end
        end
        S_BLANK: begin
          if (blank_cnt_q == '0) begin
            state_q <= S_LATCH;
            latch_q <= 1'b1;
          end else begin
            blank_cnt_q <= blank_cnt_q - BLANK_W'(1);
          end
        end
        S_LATCH: begin
          row_act_q  <= row_q;
          disp_cnt_q <= CNT_W'(BASE_TIME) << plane_q;
          if (plane_q == PLANE_LAST) begin
            plane_q <= '0;
            row_q   <= row_q + ROW_WIDTH'(1);
          end else begin
            plane_q <= plane_q + PLANE_W'(1);
          end
          if ((plane_q == PLANE_LAST) && (row_q == ROW_LAST)) begin
            if (enable) begin
              state_q  <= S_LOAD;
              load_q   <= 1'b1;
              fstart_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            state_q <= S_LOAD;
            load_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign column_address     = col_q;
  assign row_address        = row_q;
  assign row_address_active = row_act_q;
  assign brightness_mask    = BPP'(1) << plane_q;
  assign pixel_load_start   = load_q;
  assign clk_pixel          = clk_pix_q;
  assign row_latch          = latch_q;
  assign output_enable      = (disp_cnt_q != '0);
  assign frame_start        = fstart_q;

endmodule

// File: tb/tb_matrix_scan_bcm.sv
// Bench for matrix_scan_bcm. Two instances share clock and enable: BASE_TIME=4
// (shift-bound) and BASE_TIME=16 (display-bound). The expected behaviour of
// each instance comes from an event schedule built from load, clock, latch and
// display-window times.
module tb_matrix_scan_bcm;

  localparam int CW   = 2;
  localparam int RW   = 1;
  localparam int BP   = 2;
  localparam int BLK  = 1;
  localparam int COLS = 4;
  localparam int ROWS = 2;

  logic clk;
  logic reset;
  logic enable;
  logic [1:0] ready;
  logic [1:0][CW-1:0] col_o;
  logic [1:0][RW-1:0] row_o;
  logic [1:0][RW-1:0] act_o;
  logic [1:0][BP-1:0] mask_o;
  logic [1:0] load_o;
  logic [1:0] clkp_o;
  logic [1:0] latch_o;
  logic [1:0] oe_o;
  logic [1:0] fs_o;

  int tests;
  int fails;
  int n;

  // Event schedule per instance.
  int t_load [2];
  int t_clk  [2];
  int t_latch[2];
  int oe_lo  [2];
  int oe_hi  [2];
  int st_lo  [2];
  int st_hi  [2];
  int col_m  [2];
  int row_m  [2];
  int plane_m[2];
  int act_m  [2];
  int frames [2];
  bit idle_m [2];
  bit fs_pend[2];

  matrix_scan_bcm #(
    .COLUMN_WIDTH(CW), .ROW_WIDTH(RW), .BPP(BP), .BASE_TIME(4), .BLANK_CYCLES(BLK)
  ) u_dut0 (
    .clk_in(clk), .reset(reset), .enable(enable), .pixel_ready(ready[0]),
    .column_address(col_o[0]), .row_address(row_o[0]), .row_address_active(act_o[0]),
    .brightness_mask(mask_o[0]), .pixel_load_start(load_o[0]), .clk_pixel(clkp_o[0]),
    .row_latch(latch_o[0]), .output_enable(oe_o[0]), .frame_start(fs_o[0])
  );

  matrix_scan_bcm #(
    .COLUMN_WIDTH(CW), .ROW_WIDTH(RW), .BPP(BP), .BASE_TIME(16), .BLANK_CYCLES(BLK)
  ) u_dut1 (
    .clk_in(clk), .reset(reset), .enable(enable), .pixel_ready(ready[1]),
    .column_address(col_o[1]), .row_address(row_o[1]), .row_address_active(act_o[1]),
    .brightness_mask(mask_o[1]), .pixel_load_start(load_o[1]), .clk_pixel(clkp_o[1]),
    .row_latch(latch_o[1]), .output_enable(oe_o[1]), .frame_start(fs_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int base_of(input int u);
    return (u == 0) ? 4 : 16;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    for (int u = 0; u < 2; u++) begin
      t_load[u]  = -1000;
      t_clk[u]   = -1000;
      t_latch[u] = -1000;
      oe_lo[u]   = 0;
      oe_hi[u]   = -1000;
      st_lo[u]   = 0;
      st_hi[u]   = -1;
      col_m[u]   = 0;
      row_m[u]   = 0;
      plane_m[u] = 0;
      act_m[u]   = 0;
      frames[u]  = 0;
      idle_m[u]  = 1'b1;
      fs_pend[u] = 1'b0;
    end
  endtask

  task automatic check_reset(input string tag);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("%s.u%0d.col", tag, u),   32'(col_o[u]),   32'd0);
      chk($sformatf("%s.u%0d.row", tag, u),   32'(row_o[u]),   32'd0);
      chk($sformatf("%s.u%0d.act", tag, u),   32'(act_o[u]),   32'd0);
      chk($sformatf("%s.u%0d.mask", tag, u),  32'(mask_o[u]),  32'd1);
      chk($sformatf("%s.u%0d.load", tag, u),  32'(load_o[u]),  32'd0);
      chk($sformatf("%s.u%0d.clkp", tag, u),  32'(clkp_o[u]),  32'd0);
      chk($sformatf("%s.u%0d.latch", tag, u), 32'(latch_o[u]), 32'd0);
      chk($sformatf("%s.u%0d.oe", tag, u),    32'(oe_o[u]),    32'd0);
      chk($sformatf("%s.u%0d.fs", tag, u),    32'(fs_o[u]),    32'd0);
    end
  endtask

  // Fetch latency for the load just issued: none in the first frame,
  // a 5-cycle hold on one chosen column of frame 2, otherwise random.
  function automatic int pick_stall(input int u);
    int r;
    if (frames[u] == 1) return 0;
    if (frames[u] == 2 && row_m[u] == 0 && plane_m[u] == 0 && col_m[u] == 1) return 5;
    r = int'($urandom_range(0, 7));
    return (r < 4) ? 0 : r - 3;
  endfunction

  task automatic check_cycle(input int u);
    string p;
    p = $sformatf("u%0d@%0d", u, n);
    chk({p, ".load"},  32'(load_o[u]),  32'(n == t_load[u]));
    chk({p, ".fs"},    32'(fs_o[u]),    32'((n == t_load[u]) && fs_pend[u]));
    chk({p, ".clkp"},  32'(clkp_o[u]),  32'(n == t_clk[u]));
    chk({p, ".latch"}, 32'(latch_o[u]), 32'(n == t_latch[u]));
    chk({p, ".oe"},    32'(oe_o[u]),    32'((n >= oe_lo[u]) && (n <= oe_hi[u])));
    chk({p, ".col"},   32'(col_o[u]),   32'(col_m[u]));
    chk({p, ".row"},   32'(row_o[u]),   32'(row_m[u]));
    chk({p, ".act"},   32'(act_o[u]),   32'(act_m[u]));
    chk({p, ".mask"},  32'(mask_o[u]),  32'(1 << plane_m[u]));
    chk({p, ".load_and_latch"}, 32'(load_o[u] & latch_o[u]), 32'd0);
    chk({p, ".oe_and_latch"},   32'(oe_o[u] & latch_o[u]),   32'd0);
  endtask

  task automatic model_update(input int u, input logic en);
    int k;
    int w;
    bit eof;
    if (n == t_load[u]) begin
      if (fs_pend[u]) begin
        frames[u]++;
        fs_pend[u] = 1'b0;
      end
      k = pick_stall(u);
      st_lo[u] = n + 1;
      st_hi[u] = n + k;
      t_clk[u] = n + 2 + k;
    end
    if (n == t_clk[u] + 1) begin
      if (col_m[u] == COLS - 1) begin
        col_m[u] = 0;
        w = (n + 1 > oe_hi[u] + 1) ? n + 1 : oe_hi[u] + 1;
        t_latch[u] = w + BLK + 1;
      end else begin
        col_m[u]++;
        t_load[u] = n + 1;
      end
    end
    if (idle_m[u]) begin
      if (en) begin
        idle_m[u]  = 1'b0;
        t_load[u]  = n + 1;
        fs_pend[u] = 1'b1;
      end
    end else if (n == t_latch[u]) begin
      oe_lo[u] = n + 1;
      oe_hi[u] = n + (base_of(u) << plane_m[u]);
      act_m[u] = row_m[u];
      eof = (plane_m[u] == BP - 1) && (row_m[u] == ROWS - 1);
      if (plane_m[u] == BP - 1) begin
        plane_m[u] = 0;
        row_m[u]   = (row_m[u] + 1) % ROWS;
      end else begin
        plane_m[u]++;
      end
      if (eof && !en) begin
        idle_m[u] = 1'b1;
      end else begin
        t_load[u] = n + 1;
        if (eof) fs_pend[u] = 1'b1;
      end
    end
  endtask

  task automatic tick(input logic en);
    @(negedge clk);
    n++;
    enable = en;
    for (int u = 0; u < 2; u++) ready[u] = !((n >= st_lo[u]) && (n <= st_hi[u]));
    for (int u = 0; u < 2; u++) check_cycle(u);
    for (int u = 0; u < 2; u++) model_update(u, en);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    tests  = 0;
    fails  = 0;
    n      = 0;
    reset  = 1'b1;
    enable = 1'b0;
    ready  = 2'b11;
    model_init();

    repeat (2) @(negedge clk);
    check_reset("por");
    reset = 1'b0;
    repeat (4) tick(1'b0);

    // Run until instance 0 is early in row 0 of its fourth frame.
    guard = 0;
    while (!(frames[0] == 4 && col_m[0] == 2) && guard < 3000) begin
      tick(1'b1);
      guard++;
    end
    chk("reach_frame4", 32'(guard < 3000), 32'd1);

    // Drop enable: both instances finish their frames, drain OE and idle.
    guard = 0;
    while (!(idle_m[0] && idle_m[1] && n > oe_hi[0] + 3 && n > oe_hi[1] + 3) && guard < 2000) begin
      tick(1'b0);
      guard++;
    end
    chk("reach_idle", 32'(guard < 2000), 32'd1);
    repeat (5) tick(1'b0);

    // Re-enable and stop partway through row 1 of the next frame.
    guard = 0;
    while (!(frames[0] == 5 && row_m[0] == 1 && col_m[0] == 1) && guard < 2000) begin
      tick(1'b1);
      guard++;
    end
    chk("reach_frame5_row1", 32'(guard < 2000), 32'd1);

    // Asynchronous reset between clock edges while shifting.
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset("async_rst");
    @(negedge clk);
    n++;
    check_reset("async_rst_held");
    reset  = 1'b0;
    enable = 1'b0;
    ready  = 2'b11;
    model_init();
    repeat (6) tick(1'b0);

    guard = 0;
    while (!(frames[0] == 1 && row_m[0] == 1) && guard < 2000) begin
      tick(1'b1);
      guard++;
    end
    chk("restart_after_reset", 32'(guard < 2000), 32'd1);
    repeat (40) tick(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/matrix_scan_bcm.md
# matrix_scan_bcm

Parametrised LED matrix scan controller and the successor to the fixed 64x32, 6-bit scanner. It sequences column shifting, row latching, blanking and binary-coded-modulation (BCM) display time for a HUB75-style panel of any width, row count and colour depth. It drives the framebuffer fetch controller through a load/ready handshake instead of fixed timing. It sits between the matrix clock domain logic and `pixel_split` / the panel pins.

## Interface
- `COLUMN_WIDTH`, 6: column address bits; columns = 2^COLUMN_WIDTH.
- `ROW_WIDTH`, 4: row-pair address bits; rows scanned = 2^ROW_WIDTH.
- `BPP`, 6: bit planes per colour; width of `brightness_mask`.
- `BASE_TIME`, 8: display cycles for bit plane 0 (≥1); plane b displays `BASE_TIME << b`.
- `BLANK_CYCLES`, 2: guard cycles with OE low before each latch (≥1).

- `clk_in`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high.
- `enable`  in  1  run scanning; sampled at frame boundaries only.
- `pixel_ready`  in  1  fetch has valid pixel data for the requested column.
- `column_address`  out  COLUMN_WIDTH  column being shifted.
- `row_address`  out  ROW_WIDTH  row being shifted.
- `row_address_active`  out  ROW_WIDTH  row currently latched/displayed.
- `brightness_mask`  out  BPP  one-hot, plane being shifted.
- `pixel_load_start`  out  1  one-cycle fetch request.
- `clk_pixel`  out  1  panel shift clock.
- `row_latch`  out  1  panel latch pulse.
- `output_enable`  out  1  active-high display enable; inverted at pins.
- `frame_start`  out  1  one-cycle pulse at start of each frame.

## Operation
- States: IDLE, LOAD, WAIT_DATA, CLK_HIGH, CLK_LOW, WAIT_DISPLAY, BLANK, LATCH.
- IDLE: entered on reset. Goes to LOAD when `enable`=1, pulsing `frame_start` in that transition cycle.
- LOAD: `pixel_load_start`=1 for exactly one cycle, then WAIT_DATA.
- WAIT_DATA: holds until `pixel_ready`=1, then goes to CLK_HIGH. No re-request while waiting; column, row and mask are stable.
- CLK_HIGH: `clk_pixel`=1 for one cycle.
- CLK_LOW: `clk_pixel`=0. If the column is not the last, increment the column and go to LOAD. Otherwise column wraps to 0 and the FSM goes to WAIT_DISPLAY.
- WAIT_DISPLAY: at least 1 cycle. Stays while the display counter ≠ 0, then goes to BLANK.
- BLANK: `BLANK_CYCLES` cycles, OE low, then LATCH.
- LATCH: `row_latch`=1 for one cycle. On exit:
  - `row_address_active` ← `row_address`.
  - Display counter ← `BASE_TIME << b`.
  - Plane index b advances; after the last plane b wraps to 0 and `row_address` increments.
- End of frame: after the LATCH of the last row and last plane, `row_address` wraps to 0.
  - If `enable`=0, go to IDLE.
  - Otherwise go to LOAD and pulse `frame_start`.
- `output_enable` = (display counter ≠ 0). The counter decrements each cycle. Display of plane b overlaps shifting of the next plane.
- Counter width is ceil(log2(BASE_TIME<<(BPP-1))+1). No overflow permitted.
- `brightness_mask` = 1 << b for the plane being shifted.
- Async `reset` mid-operation: everything returns to reset values immediately and the FSM goes to IDLE.

## Timing
- Reset values:
  - All outputs are 0, except `brightness_mask` = 1.
  - Display counter is 0 and the FSM is in IDLE.
- Per column minimum: 4 cycles (LOAD, WAIT_DATA with ready high, CLK_HIGH, CLK_LOW).
  - Each cycle of `pixel_ready` low adds one cycle.
- Last CLK_LOW → WAIT_DISPLAY → BLANK (×BLANK_CYCLES) → LATCH.
  - Minimum latch delay is 2+BLANK_CYCLES cycles after the last CLK_LOW.
- OE rises in the cycle after LATCH and stays high exactly `BASE_TIME << b` cycles, where b is the latched plane.
- If display time exceeds shift time, the FSM stalls in WAIT_DISPLAY. There is never a latch while OE is high.
- `pixel_load_start` and `row_latch` are never high in the same cycle.
- `frame_start` is high in the same cycle as the first LOAD of row 0, plane 0.

## Test plan
All scenarios use COLUMN_WIDTH=2, ROW_WIDTH=1, BPP=2, BASE_TIME=4, BLANK_CYCLES=1 unless stated.
- Reset: assert `reset` asynchronously mid-shift (between clock edges) → outputs clear immediately; `brightness_mask`=01; no activity until `enable`=1.
- Steady shift, `pixel_ready` tied 1:
  - 4 `clk_pixel` pulses with period 4; `column_address` runs 0,1,2,3.
  - `row_latch` occurs 3 cycles after the 4th CLK_LOW; `row_address_active`=0 afterwards.
- BCM timing: after the plane-0 latch, OE is high for 4 cycles; after the plane-1 latch, OE is high for 8 cycles. No stall, since shift takes 16 cycles.
- Display stall, BASE_TIME=16: plane-1 OE is high for 32 cycles. The FSM waits in WAIT_DISPLAY until OE falls, then gives 1 blank cycle, then latches. OE and `row_latch` never overlap.
- Backpressure: hold `pixel_ready` low for 5 cycles after a LOAD → `clk_pixel` stays 0, `column_address` is stable, and only one `pixel_load_start` pulse is issued.
- Stop: drop `enable` during row 0 → the frame completes through row 1 plane 1, `row_address` wraps to 0, and the FSM enters IDLE. The last OE window runs 8 cycles and then stays low. Re-raising `enable` gives exactly one `frame_start` pulse.
